// File: rtl/ramp_sequencer.sv
// Triangle-ramp brightness sequencer: steps a level up/down at a prescaled rate,
// rotates it across LED channels after a set number of periods, and PWMs each LED.
module ramp_sequencer #(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 16,
   parameter int NUM_CH     = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  loop,
   input  logic [PRESCALE_W-1:0] prescale,
   input  logic [3:0]            cycles,
   output logic [WIDTH-1:0]      level,
   output logic [NUM_CH-1:0]     ch_sel,
   output logic [NUM_CH-1:0]     led,
   output logic                  busy,
   output logic                  done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RISE = 2'd1;
   localparam logic [1:0] S_FALL = 2'd2;
   localparam logic [1:0] S_NEXT = 2'd3;

   localparam logic [WIDTH-1:0]  LVL_MAX  = '1;
   localparam logic [NUM_CH-1:0] CH_FIRST = NUM_CH'(1);

   logic [1:0]            state_q, state_d;
   logic [WIDTH-1:0]      level_q, level_d;
   logic [NUM_CH-1:0]     ch_q, ch_d;
   logic [NUM_CH-1:0]     led_q, led_d;
   logic                  done_q, done_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [3:0]            period_q, period_d;
   logic [3:0]            cycles_q, cycles_d;
   logic [WIDTH-1:0]      pwm_q;

   logic                  step;
   logic                  busy_w;
   logic [WIDTH-1:0]      level_inc, level_dec;
   logic [3:0]            period_inc;

   assign busy_w     = (state_q != S_IDLE);
   assign step       = (presc_q == prescale_q);
   assign level_inc  = level_q + WIDTH'(1);
   assign level_dec  = level_q - WIDTH'(1);
   assign period_inc = period_q + 4'd1;

   always_comb begin
      state_d    = state_q;
      level_d    = level_q;
      ch_d       = ch_q;
      done_d     = 1'b0;
      presc_d    = presc_q;
      period_d   = period_q;
      prescale_d = prescale_q;
      cycles_d   = cycles_q;
      case (state_q)
         S_IDLE: begin
            if (start && !stop) begin
               state_d    = S_RISE;
               prescale_d = prescale;
               cycles_d   = cycles;
               presc_d    = '0;
               period_d   = '0;
               level_d    = '0;
               ch_d       = CH_FIRST;
            end
         end
         S_RISE, S_FALL: begin
            presc_d = step ? '0 : presc_q + PRESCALE_W'(1);
            if (step && state_q == S_RISE) begin
               level_d = level_inc;
               if (level_inc == LVL_MAX) state_d = S_FALL;
            end else if (step) begin
               level_d = level_dec;
               // Reaching zero on the way down closes one full period
               if (level_dec == '0) begin
                  if (cycles_q != 4'd0 && period_inc == cycles_q) begin
                     state_d  = S_NEXT;
                     period_d = '0;
                  end else begin
                     state_d  = S_RISE;
                     period_d = period_inc;
                  end
               end
            end
         end
         S_NEXT: begin
            presc_d = '0;
            if (ch_q[NUM_CH-1]) begin
               ch_d    = CH_FIRST;
               done_d  = 1'b1;
               state_d = loop ? S_RISE : S_IDLE;
            end else begin
               ch_d    = ch_q << 1;
               state_d = S_RISE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Abort overrides whatever the active state decided, including a done pulse
      if (stop && busy_w) begin
         state_d  = S_IDLE;
         level_d  = '0;
         ch_d     = CH_FIRST;
         period_d = '0;
         presc_d  = '0;
         done_d   = 1'b0;
      end
   end

   always_comb begin
      led_d = ch_q & {NUM_CH{busy_w}} & {NUM_CH{pwm_q < level_q}};
      if (stop && busy_w) led_d = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         level_q    <= '0;
         ch_q       <= CH_FIRST;
         led_q      <= '0;
         done_q     <= 1'b0;
         presc_q    <= '0;
         prescale_q <= '0;
         period_q   <= '0;
         cycles_q   <= '0;
         pwm_q      <= '0;
      end else begin
         state_q    <= state_d;
         level_q    <= level_d;
         ch_q       <= ch_d;
         led_q      <= led_d;
         done_q     <= done_d;
         presc_q    <= presc_d;
         prescale_q <= prescale_d;
         period_q   <= period_d;
         cycles_q   <= cycles_d;
         pwm_q      <= pwm_q + WIDTH'(1);
      end
   end

   assign level  = level_q;
   assign ch_sel = ch_q;
   assign led    = led_q;
   assign busy   = busy_w;
   assign done   = done_q;

endmodule

// File: tb/tb_ramp_sequencer.sv
// Bench for ramp_sequencer: timing table, corner-case sequences, and random
// stimulus checked every cycle against a step-position reference model.
module tb_ramp_sequencer;
   localparam int W   = 4;
   localparam int PW  = 8;
   localparam int NC  = 3;
   localparam int TOP = (1 << W) - 1;
   localparam int PER = 2 * TOP;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0, stop = 1'b0, loop = 1'b0;
   logic [PW-1:0] prescale = '0;
   logic [3:0]    cycles = '0;
   logic [W-1:0]  level;
   logic [NC-1:0] ch_sel, led;
   logic          busy, done;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit mchk  = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ramp_sequencer #(.WIDTH(W), .PRESCALE_W(PW), .NUM_CH(NC)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop), .loop(loop),
      .prescale(prescale), .cycles(cycles), .level(level), .ch_sel(ch_sel),
      .led(led), .busy(busy), .done(done)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: position within the period in steps, level derived arithmetically
   int m_busy, m_ch, m_idx, m_pc, m_per, m_next, m_done, m_pwm, m_presc, m_cyc;
   logic [NC-1:0] m_led;

   function automatic int m_lvl();
      return (m_idx <= TOP) ? m_idx : PER - m_idx;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy = 0; m_ch = 0; m_idx = 0; m_pc = 0; m_per = 0; m_next = 0;
         m_done = 0; m_pwm = 0; m_presc = 0; m_cyc = 0; m_led = '0;
      end else begin
         int lvl;
         lvl   = m_lvl();
         m_led = '0;
         if (m_busy != 0 && !stop)
            for (int i = 0; i < NC; i++) m_led[i] = (i == m_ch) && (m_pwm < lvl);
         m_done = 0;
         if (m_busy == 0) begin
            if (start && !stop) begin
               m_busy = 1; m_ch = 0; m_idx = 0; m_pc = 0; m_per = 0; m_next = 0;
               m_presc = int'(prescale); m_cyc = int'(cycles);
            end
         end else if (stop) begin
            m_busy = 0; m_ch = 0; m_idx = 0; m_per = 0; m_next = 0; m_pc = 0;
         end else if (m_next != 0) begin
            m_next = 0; m_pc = 0;
            if (m_ch == NC - 1) begin
               m_ch = 0; m_done = 1; m_busy = loop ? 1 : 0;
            end else m_ch++;
         end else if (m_pc == m_presc) begin
            m_pc = 0;
            m_idx++;
            if (m_idx == PER) begin
               m_idx = 0;
               if (m_cyc != 0 && m_per + 1 == m_cyc) begin m_per = 0; m_next = 1; end
               else m_per = (m_per + 1) % 16;
            end
         end else m_pc++;
         m_pwm = (m_pwm + 1) % (1 << W);
      end
   end

   always @(negedge clk) begin
      if (mchk) begin
         chk("model_level", level, m_lvl());
         chk("model_ch_sel", ch_sel, 1 << m_ch);
         chk("model_led", led, m_led);
         chk("model_busy", busy, m_busy);
         chk("model_done", done, m_done);
      end
   end

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic goto_cyc(input int t);
      while (cyc < t) tick(1);
   endtask

   task automatic kick(output int n0);
      n0 = cyc; start = 1'b1; tick(1); start = 1'b0;
   endtask

   task automatic abort();
      stop = 1'b1; tick(1); stop = 1'b0; tick(1);
   endtask

   typedef struct {
      int            off;
      logic [W-1:0]  lvl;
      logic [NC-1:0] ch;
      logic          bsy;
      logic          dn;
   } vec_t;

   vec_t tv [13];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1, dn_cnt, ch_moves, peaks, w, on_act, on_other;
      int tgt [3];

      tv = '{ '{ 1, 4'd0,  3'b001, 1'b1, 1'b0}, '{ 2, 4'd1,  3'b001, 1'b1, 1'b0},
              '{16, 4'd15, 3'b001, 1'b1, 1'b0}, '{17, 4'd14, 3'b001, 1'b1, 1'b0},
              '{30, 4'd1,  3'b001, 1'b1, 1'b0}, '{31, 4'd0,  3'b001, 1'b1, 1'b0},
              '{32, 4'd0,  3'b010, 1'b1, 1'b0}, '{33, 4'd1,  3'b010, 1'b1, 1'b0},
              '{62, 4'd0,  3'b010, 1'b1, 1'b0}, '{63, 4'd0,  3'b100, 1'b1, 1'b0},
              '{93, 4'd0,  3'b100, 1'b1, 1'b0}, '{94, 4'd0,  3'b001, 1'b0, 1'b1},
              '{95, 4'd0,  3'b001, 1'b0, 1'b0} };
      tgt = '{0, 8, 15};

      tick(3);
      chk("rst_level", level, 0);
      chk("rst_ch_sel", ch_sel, 3'b001);
      chk("rst_led", led, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      rst = 1'b0; mchk = 1'b1;
      tick(2);

      // Full three-channel sequence, prescale 0, one period per channel
      prescale = 0; cycles = 1; loop = 0;
      kick(n0);
      foreach (tv[i]) begin
         goto_cyc(n0 + tv[i].off);
         chk($sformatf("tbl%0d_level", i), level, tv[i].lvl);
         chk($sformatf("tbl%0d_ch_sel", i), ch_sel, tv[i].ch);
         chk($sformatf("tbl%0d_busy", i), busy, tv[i].bsy);
         chk($sformatf("tbl%0d_done", i), done, tv[i].dn);
      end
      tick(3);

      // Prescaled stepping, two periods before rotation
      prescale = 3; cycles = 2;
      kick(n0);
      prescale = 0; cycles = 1;
      goto_cyc(n0 + 4);   chk("ps_level_n4", level, 0);
      goto_cyc(n0 + 5);   chk("ps_level_n5", level, 1);
      goto_cyc(n0 + 8);   chk("ps_level_n8", level, 1);
      goto_cyc(n0 + 9);   chk("ps_level_n9", level, 2);
      goto_cyc(n0 + 241); chk("ps_ch_n241", ch_sel, 3'b001);
      goto_cyc(n0 + 242); chk("ps_ch_n242", ch_sel, 3'b010);
      abort();
      chk("ps_abort_busy", busy, 0);

      // cycles=0 stays on channel 0 forever
      prescale = 0; cycles = 0;
      kick(n0);
      dn_cnt = 0; ch_moves = 0; peaks = 0;
      repeat (150) begin
         if (done) dn_cnt++;
         if (ch_sel != 3'b001) ch_moves++;
         if (level == 4'd15) peaks++;
         tick(1);
      end
      chk("c0_done_cnt", dn_cnt, 0);
      chk("c0_ch_moves", ch_moves, 0);
      chk("c0_peaks", peaks, 5);
      abort();

      // Simultaneous stop+start mid-rise, then a lone restart
      cycles = 1;
      kick(n0);
      goto_cyc(n0 + 10);
      chk("ss_pre_level", level, 9);
      stop = 1'b1; start = 1'b1; tick(1); stop = 1'b0; start = 1'b0;
      chk("ss_busy", busy, 0);
      chk("ss_level", level, 0);
      chk("ss_led", led, 0);
      chk("ss_ch_sel", ch_sel, 3'b001);
      chk("ss_done", done, 0);
      tick(3);
      chk("ss_idle_level", level, 0);
      kick(n1);
      chk("ss_restart_busy", busy, 1);
      goto_cyc(n1 + 2);
      chk("ss_restart_level", level, 1);
      abort();

      // Looping: done pulses at the wrap but the sequence continues
      loop = 1'b1;
      kick(n0);
      goto_cyc(n0 + 94);
      chk("lp_done", done, 1);
      chk("lp_busy", busy, 1);
      chk("lp_ch_sel", ch_sel, 3'b001);
      goto_cyc(n0 + 95);
      chk("lp_done_clr", done, 0);
      chk("lp_level", level, 1);
      chk("lp_busy2", busy, 1);
      abort();
      loop = 1'b0;

      // PWM duty at held levels with the slowest step rate
      prescale = '1;
      kick(n0);
      prescale = 0;
      for (int k = 0; k < 3; k++) begin
         w = 0;
         while (level != tgt[k] && w < 5000) begin tick(1); w++; end
         chk($sformatf("pwm%0d_reach", tgt[k]), level, tgt[k]);
         tick(2);
         on_act = 0; on_other = 0;
         repeat (32) begin
            if (led[0]) on_act++;
            if (led[2:1] != 0) on_other++;
            tick(1);
         end
         chk($sformatf("pwm%0d_on", tgt[k]), on_act, 2 * tgt[k]);
         chk($sformatf("pwm%0d_other", tgt[k]), on_other, 0);
      end

      // Asynchronous reset between clock edges
      chk("ar_pre_busy", busy, 1);
      @(posedge clk); #3;
      rst = 1'b1; #1;
      chk("ar_level", level, 0);
      chk("ar_ch_sel", ch_sel, 3'b001);
      chk("ar_led", led, 0);
      chk("ar_busy", busy, 0);
      chk("ar_done", done, 0);
      tick(2);
      rst = 1'b0;
      tick(2);

      // Random traffic against the model
      repeat (3000) begin
         start    = ($urandom % 20) == 0;
         stop     = ($urandom % 400) == 0;
         loop     = $urandom % 2;
         prescale = PW'($urandom % 3);
         cycles   = 4'($urandom % 3);
         tick(1);
      end
      start = 1'b0; stop = 1'b0;
      tick(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
